// File: rtl/slam_move_scheduler.sv
// slam_move_scheduler: arbitrates host dead-reckoning commands (FIFO) and
// per-channel spike events (pending counters) onto a single {dir, step}
// valid/ready update port. Host bursts are bounded while spikes wait.
module slam_move_scheduler #(
  parameter int CMD_DEPTH  = 4,
  parameter int PEND_MAX   = 7,
  parameter int HOST_BURST = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [3:0]                   spike_in,
  input  logic [31:0]                  weights,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [17:0]                  cmd_data,
  output logic                         upd_valid,
  input  logic                         upd_ready,
  output logic [1:0]                   upd_dir,
  output logic [15:0]                  upd_step,
  output logic                         upd_src,
  output logic [$clog2(CMD_DEPTH):0]   fifo_level,
  output logic [4:0]                   ovf,
  input  logic                         ovf_clr
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int SW = $clog2(HOST_BURST + 1);
  localparam logic [PW-1:0] PMAX  = PW'(PEND_MAX);
  localparam logic [SW-1:0] SMAX  = SW'(HOST_BURST);
  localparam logic [AW:0]   DEPTH = (AW+1)'(CMD_DEPTH);

  logic [CMD_DEPTH-1:0][17:0] fifo_q, fifo_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                count_q, count_d;
  logic [3:0][PW-1:0]         pend_q, pend_d;
  logic [1:0]                 rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]              streak_q, streak_d;
  logic [3:0]                 prev_spike_q, prev_spike_d;
  logic [3:0]                 ovf_q, ovf_d;
  logic                       upd_valid_q, upd_valid_d;
  logic [1:0]                 upd_dir_q, upd_dir_d;
  logic [15:0]                upd_step_q, upd_step_d;
  logic                       upd_src_q, upd_src_d;

  logic       fifo_nonempty, spike_pending, host_sel, load, push, pop;
  logic       found;
  logic [1:0] pick, idx;
  logic [3:0] rise, grant;

  assign cmd_ready  = (count_q != DEPTH);
  assign upd_valid  = upd_valid_q;
  assign upd_dir    = upd_dir_q;
  assign upd_step   = upd_step_q;
  assign upd_src    = upd_src_q;
  assign fifo_level = count_q;
  assign ovf        = {1'b0, ovf_q};

  // Arbitration: round-robin spike pick, bounded host streak, load decision
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = rr_ptr_q + 2'(j);
      if (!found && pend_q[idx] != '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    fifo_nonempty = (count_q != '0);
    spike_pending = found;
    host_sel      = fifo_nonempty & ((streak_q < SMAX) | !spike_pending);
    load          = enable & (!upd_valid_q | upd_ready) & (fifo_nonempty | spike_pending);
    pop           = load & host_sel;
    push          = cmd_valid & cmd_ready & !flush;
    rise          = spike_in & ~prev_spike_q & {4{!flush}};
    grant         = '0;
    if (load && !host_sel) grant[pick] = 1'b1;
  end

  // Next state: FIFO, pending counters, overflow, streak, output register
  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_d       = pend_q;
    rr_ptr_d     = rr_ptr_q;
    streak_d     = streak_q;
    prev_spike_d = spike_in;
    ovf_d        = ovf_clr ? 4'b0 : ovf_q;
    upd_valid_d  = upd_valid_q;
    upd_dir_d    = upd_dir_q;
    upd_step_d   = upd_step_q;
    upd_src_d    = upd_src_q;

    // host FIFO; cmd_ready never looks at a same-cycle pop
    if (push) begin
      fifo_d[wr_ptr_q] = cmd_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    // pending counters: rise and grant together cancel out
    for (int i = 0; i < 4; i++) begin
      if (rise[i] && !grant[i]) begin
        if (pend_q[i] == PMAX) ovf_d[i] = 1'b1;
        else                   pend_d[i] = pend_q[i] + PW'(1);
      end else if (grant[i] && !rise[i]) begin
        pend_d[i] = pend_q[i] - PW'(1);
      end
    end

    // streak counts host grants made while a spike is waiting
    if (load && !host_sel)  streak_d = '0;
    else if (!spike_pending) streak_d = '0;
    else if (pop && streak_q != SMAX) streak_d = streak_q + SW'(1);

    // output register
    if (load) begin
      upd_valid_d = 1'b1;
      if (host_sel) begin
        upd_dir_d  = fifo_q[rd_ptr_q][17:16];
        upd_step_d = fifo_q[rd_ptr_q][15:0];
        upd_src_d  = 1'b0;
      end else begin
        upd_dir_d  = pick;
        upd_step_d = {8'h0, weights[{pick, 3'b000} +: 8]};
        upd_src_d  = 1'b1;
        rr_ptr_d   = pick + 2'd1;
      end
    end else if (upd_ready) begin
      upd_valid_d = 1'b0;
    end

    // flush drops queued work but leaves rr_ptr, ovf and the held update
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = '0;
      streak_d = '0;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      streak_q     <= '0;
      prev_spike_q <= '0;
      ovf_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_dir_q    <= '0;
      upd_step_q   <= '0;
      upd_src_q    <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      streak_q     <= streak_d;
      prev_spike_q <= prev_spike_d;
      ovf_q        <= ovf_d;
      upd_valid_q  <= upd_valid_d;
      upd_dir_q    <= upd_dir_d;
      upd_step_q   <= upd_step_d;
      upd_src_q    <= upd_src_d;
    end
  end

endmodule

// File: tb/tb_slam_move_scheduler.sv
// tb_slam_move_scheduler: directed, table-driven checks of the move scheduler.
module tb_slam_move_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, flush, cmd_valid, cmd_ready, upd_valid, upd_ready;
  logic        upd_src, ovf_clr;
  logic [3:0]  spike_in;
  logic [31:0] weights;
  logic [17:0] cmd_data;
  logic [1:0]  upd_dir;
  logic [15:0] upd_step;
  logic [2:0]  fifo_level;
  logic [4:0]  ovf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [17:0] cmd;
    logic [1:0]  edir;
    logic [15:0] estep;
    logic        esrc;
  } vec_t;

  vec_t t2[4];
  vec_t t4[4];
  vec_t t5[5];

  slam_move_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .spike_in(spike_in),
    .weights(weights), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_dir(upd_dir), .upd_step(upd_step), .upd_src(upd_src),
    .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // valid + payload as one packed value {valid, dir, step, src}
  task automatic chk_upd(input string nm, input logic [1:0] d, input logic [15:0] s, input logic src);
    chk(nm, {12'h0, upd_valid, upd_dir, upd_step, upd_src}, {12'h0, 1'b1, d, s, src});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [17:0] c);
    cmd_valid = 1'b1;
    cmd_data  = c;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int acc, cnt;
    t2[0] = '{{2'd0, 16'd5}, 2'd0, 16'd5, 1'b0};
    t2[1] = '{{2'd1, 16'd7}, 2'd1, 16'd7, 1'b0};
    t2[2] = '{{2'd2, 16'd3}, 2'd2, 16'd3, 1'b0};
    t2[3] = '{{2'd3, 16'd1}, 2'd3, 16'd1, 1'b0};
    t4[0] = '{18'h0, 2'd0, 16'd1, 1'b1};
    t4[1] = '{18'h0, 2'd1, 16'd2, 1'b1};
    t4[2] = '{18'h0, 2'd2, 16'd3, 1'b1};
    t4[3] = '{18'h0, 2'd3, 16'd4, 1'b1};
    t5[0] = '{{2'd0, 16'd10}, 2'd0, 16'd10, 1'b0};
    t5[1] = '{{2'd1, 16'd11}, 2'd1, 16'd11, 1'b0};
    t5[2] = '{{2'd2, 16'd12}, 2'd1, 16'd2,  1'b1};
    t5[3] = '{{2'd3, 16'd13}, 2'd2, 16'd12, 1'b0};
    t5[4] = '{18'h0,          2'd3, 16'd13, 1'b0};

    rst = 1'b1; enable = 1'b0; flush = 1'b0; spike_in = '0; cmd_valid = 1'b0;
    cmd_data = '0; upd_ready = 1'b0; ovf_clr = 1'b0;
    weights = {8'd4, 8'd3, 8'd2, 8'd1};
    repeat (2) @(negedge clk);
    chk("reset_state", {upd_valid, cmd_ready, fifo_level, ovf, upd_dir, upd_step, upd_src},
        {1'b0, 1'b1, 3'd0, 5'd0, 2'd0, 16'd0, 1'b0});
    rst = 1'b0;
    step();

    // host latency from idle
    enable = 1'b1; upd_ready = 1'b1;
    push({2'd0, 16'd5});
    chk("lat_host_early", {upd_valid, fifo_level}, {1'b0, 3'd1});
    step();
    chk_upd("lat_host_out", 2'd0, 16'd5, 1'b0);
    step();
    chk("lat_host_drain", {upd_valid, fifo_level}, {1'b0, 3'd0});

    // T2: host FIFO order
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(t2[i].cmd);
    chk("t2_full", {fifo_level, cmd_ready}, {3'd4, 1'b0});
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_upd($sformatf("t2_upd%0d", i), t2[i].edir, t2[i].estep, t2[i].esrc);
    end
    step();
    chk("t2_idle", upd_valid, 1'b0);

    // T3: backpressure, 6 offered, 5 accepted
    upd_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1;
      cmd_data  = {2'(k), 16'(100 + k)};
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("t3_accepted", acc, 5);
    chk("t3_full", {fifo_level, cmd_ready}, {3'd4, 1'b0});
    chk_upd("t3_held", 2'd0, 16'd100, 1'b0);
    step(); step();
    chk_upd("t3_stable", 2'd0, 16'd100, 1'b0);
    upd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_upd($sformatf("t3_upd%0d", k), 2'(k), 16'(100 + k), 1'b0);
      step();
    end
    chk("t3_idle", upd_valid, 1'b0);

    // T4: round-robin over all four channels, spike latency
    spike_in = 4'hF;
    step();
    spike_in = 4'h0;
    chk("t4_lat_early", upd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_upd($sformatf("t4_upd%0d", i), t4[i].edir, t4[i].estep, t4[i].esrc);
    end
    // rr_ptr wrapped to 0: channel 0 wins over channel 3
    spike_in = 4'b1001;
    step();
    spike_in = 4'h0;
    step();
    chk_upd("t4_rr0", 2'd0, 16'd1, 1'b1);
    step();
    chk_upd("t4_rr3", 2'd3, 16'd4, 1'b1);
    step();
    chk("t4_idle", upd_valid, 1'b0);

    // T5: starvation bound H,H,S1,H,H
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(t5[i].cmd);
    spike_in = 4'b0010;
    step();
    spike_in = 4'h0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_upd($sformatf("t5_g%0d", i), t5[i].edir, t5[i].estep, t5[i].esrc);
    end
    step();
    chk("t5_idle", upd_valid, 1'b0);

    // T6: saturation at PEND_MAX, overflow sticky then cleared
    enable = 1'b0;
    for (int r = 0; r < 9; r++) begin
      spike_in = 4'b0100;
      step();
      spike_in = 4'h0;
      step();
      if (r == 6) chk("t6_no_ovf_at_max", ovf, 5'b0);
    end
    chk("t6_ovf", ovf, 5'b00100);
    enable = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (upd_valid && upd_dir == 2'd2 && upd_step == 16'd3 && upd_src) cnt++;
    end
    chk("t6_count", cnt, 7);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", ovf, 5'b0);

    // flush: discards queue, pending, and same-cycle push/rise
    enable = 1'b0;
    push({2'd1, 16'd9});
    spike_in = 4'b0001;
    step();
    spike_in = 4'h0;
    step();
    flush = 1'b1; cmd_valid = 1'b1; cmd_data = {2'd2, 16'd8}; spike_in = 4'b0010;
    step();
    flush = 1'b0; cmd_valid = 1'b0; spike_in = 4'h0;
    chk("flush_level", fifo_level, 3'd0);
    enable = 1'b1;
    step(); step();
    chk("flush_no_upd", upd_valid, 1'b0);

    // T1: asynchronous reset while an update is held
    enable = 1'b0; upd_ready = 1'b0;
    push({2'd3, 16'd77});
    push({2'd2, 16'd66});
    enable = 1'b1;
    step();
    chk_upd("t1_held", 2'd3, 16'd77, 1'b0);
    #2 rst = 1'b1;
    #1 chk("t1_async", {upd_valid, fifo_level, ovf, cmd_ready}, {1'b0, 3'd0, 5'd0, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
